// File: rtl/fifo_uart_tx.sv
// Drains a synchronous FIFO one word at a time onto a UART-style serial line:
// start bit, WIDTH data bits LSB first, stop bit; line idles high.
module fifo_uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_rd_en,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(WIDTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LOAD,
        START,
        DATA,
        STOP
    } state_t;

    state_t            state_reg;
    logic [BAUD_W-1:0] baud_reg;
    logic [BIT_W-1:0]  bit_reg;
    logic [WIDTH-1:0]  shift_reg;
    logic [WIDTH-1:0]  shift_next;
    logic              tx_reg;
    logic              rd_en_reg;
    logic              done_reg;

    // tx is registered, so the next data bit is taken from the post-shift value
    assign shift_next = shift_reg >> 1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
            baud_reg  <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            tx_reg    <= 1'b1;
            rd_en_reg <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            rd_en_reg <= 1'b0;
            done_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    tx_reg <= 1'b1;
                    if (!fifo_empty) begin
                        rd_en_reg <= 1'b1;
                        state_reg <= READ;
                    end
                end
                READ: begin
                    state_reg <= LOAD;
                end
                LOAD: begin
                    shift_reg <= fifo_data;
                    baud_reg  <= '0;
                    bit_reg   <= '0;
                    tx_reg    <= 1'b0;
                    state_reg <= START;
                end
                START: begin
                    if (baud_reg == BAUD_LAST) begin
                        baud_reg  <= '0;
                        tx_reg    <= shift_reg[0];
                        state_reg <= DATA;
                    end else begin
                        baud_reg <= baud_reg + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_reg == BAUD_LAST) begin
                        baud_reg  <= '0;
                        shift_reg <= shift_next;
                        bit_reg   <= bit_reg + 1'b1;
                        if (bit_reg == BIT_LAST) begin
                            tx_reg    <= 1'b1;
                            state_reg <= STOP;
                        end else begin
                            tx_reg <= shift_next[0];
                        end
                    end else begin
                        baud_reg <= baud_reg + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_reg == BAUD_LAST) begin
                        baud_reg  <= '0;
                        done_reg  <= 1'b1;
                        state_reg <= IDLE;
                    end else begin
                        baud_reg <= baud_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign tx         = tx_reg;
    assign fifo_rd_en = rd_en_reg;
    assign frame_done = done_reg;
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model + frame scoreboard on a WIDTH=8/CLKS_PER_BIT=4
// instance, plus a sweep of six parameter sets each with its own UART receiver.
module tb_fifo_uart_tx;

    localparam int W   = 8;
    localparam int CPB = 4;

    logic         clk = 1'b0;
    logic         rstn = 1'b1;
    logic         fifo_empty = 1'b1;
    logic [W-1:0] fifo_data = '0;
    logic         fifo_rd_en;
    logic         tx;
    logic         busy;
    logic         frame_done;

    always #5 clk = ~clk;

    fifo_uart_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB)) u_dut (
        .clk        (clk),
        .rstn       (rstn),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    int checks = 0;
    int errors = 0;
    int sw_fin = 0;
    logic sw_go = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endfunction

    function automatic void sweep_finished();
        sw_fin++;
    endfunction

    // FIFO model: registered data_out, empty guard on reads
    logic         wr_en = 1'b0;
    logic [W-1:0] wr_data = '0;
    logic [W-1:0] fq[$];
    always @(posedge clk) begin
        if (fifo_rd_en && fq.size() > 0) fifo_data <= fq.pop_front();
        if (wr_en) fq.push_back(wr_data);
        fifo_empty <= (fq.size() == 0);
    end

    // Scoreboard of expected line frames, bit 0 = start bit
    logic [W+1:0] exp_q[$];
    int gap_q[$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pops = 0, dones = 0, starts = 0, aborts = 0, adj_cnt = 0;
    int last_rd_cyc = 0, last_done_cyc = 0, stop_cyc = 0;
    bit stop_seen = 0;

    initial begin : event_counter
        logic rd_prev;
        rd_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (fifo_rd_en === 1'b1) begin
                pops++;
                if (rd_prev) adj_cnt++;
                last_rd_cyc = cyc;
            end
            rd_prev = (fifo_rd_en === 1'b1);
            if (frame_done === 1'b1) begin
                dones++;
                last_done_cyc = cyc;
            end
        end
    end

    initial begin : frame_monitor
        logic [W+1:0] expf, got;
        bit ok, aborted;
        forever begin
            @(negedge clk);
            if (rstn === 1'b1 && tx === 1'b0) begin
                starts++;
                check("rd_to_start", cyc - last_rd_cyc, 2);
                if (stop_seen) gap_q.push_back(cyc - stop_cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got a start bit, expected an empty scoreboard to stay idle");
                    expf = '0;
                end else begin
                    expf = exp_q.pop_front();
                end
                ok = 1'b1;
                aborted = 1'b0;
                got = '0;
                for (int b = 0; b < W + 2 && !aborted; b++) begin
                    for (int c = 0; c < CPB && !aborted; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (rstn !== 1'b1) begin
                            aborted = 1'b1;
                        end else begin
                            if (c == 0) got[b] = tx;
                            else if (tx !== got[b]) ok = 1'b0;
                            if (b == W + 1 && c == 0) stop_cyc = cyc;
                        end
                    end
                end
                if (aborted) begin
                    aborts++;
                    stop_seen = 0;
                    $display("frame aborted by reset (expected frame 'h%0h)", expf);
                end else begin
                    stop_seen = 1;
                    check("frame_bits", 32'(got), 32'(expf));
                    check("bit_hold", 32'(ok), 1);
                    $display("frame: line 'h%0h expected 'h%0h word 'h%0h", got, expf, got[W:1]);
                end
            end
        end
    end

    function automatic int get_count(input int which);
        case (which)
            0: return pops;
            1: return dones;
            default: return starts;
        endcase
    endfunction

    task automatic wait_count(input int which, input int target, input int budget, input string name);
        int n;
        n = 0;
        while (get_count(which) < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (get_count(which) < target) begin
            errors++;
            $display("FAIL %s_timeout: got count %0d, expected %0d", name, get_count(which), target);
        end
    endtask

    task automatic push_word(input logic [W-1:0] d, input logic [W+1:0] frame);
        @(negedge clk);
        wr_en = 1'b1;
        wr_data = d;
        exp_q.push_back(frame);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    typedef struct {
        logic [W-1:0] data;
        logic [W+1:0] frame;
    } vec_t;
    vec_t vecs[5];

    initial begin : main
        int p0, d0, s0, a0, bad, done_cyc, n;
        vecs[0] = '{8'hA5, 10'h34A};
        vecs[1] = '{8'h00, 10'h200};
        vecs[2] = '{8'hFF, 10'h3FE};
        vecs[3] = '{8'h3C, 10'h278};
        vecs[4] = '{8'h55, 10'h2AA};

        // reset and idle
        #1 rstn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 1);
        check("rst_rd_en", 32'(fifo_rd_en), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        rstn = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || fifo_rd_en !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) bad++;
        end
        check("idle_hold_bad_cycles", 32'(bad), 0);

        // single words from the table
        for (int i = 0; i < 5; i++) begin
            p0 = pops;
            d0 = dones;
            push_word(vecs[i].data, vecs[i].frame);
            wait_count(1, d0 + 1, 200, "single_done");
            repeat (3) @(negedge clk);
            check("single_pops", 32'(pops - p0), 1);
            check("single_dones", 32'(dones - d0), 1);
            check("single_fifo_empty", 32'(fifo_empty), 1);
            check("single_busy_after", 32'(busy), 0);
            check("single_tx_after", 32'(tx), 1);
        end

        // back-to-back words
        p0 = pops;
        d0 = dones;
        gap_q.delete();
        for (int i = 1; i <= 3; i++) push_word(vecs[i].data, vecs[i].frame);
        wait_count(1, d0 + 3, 600, "b2b_done");
        repeat (3) @(negedge clk);
        check("b2b_pops", 32'(pops - p0), 3);
        check("b2b_gap_count", 32'(gap_q.size()), 3);
        if (gap_q.size() == 3) begin
            check("b2b_gap1", 32'(gap_q[1]), CPB + 3);
            check("b2b_gap2", 32'(gap_q[2]), CPB + 3);
        end

        // FIFO becomes non-empty mid-frame: second pop must wait for IDLE
        p0 = pops;
        d0 = dones;
        s0 = starts;
        push_word(vecs[0].data, vecs[0].frame);
        wait_count(2, s0 + 1, 50, "gate_start");
        repeat (CPB * 3) @(negedge clk);
        push_word(vecs[4].data, vecs[4].frame);
        repeat (CPB * 2) @(negedge clk);
        check("gate_no_early_pop", 32'(pops - p0), 1);
        wait_count(1, d0 + 1, 200, "gate_done1");
        done_cyc = last_done_cyc;
        wait_count(0, p0 + 2, 20, "gate_pop2");
        check("gate_pop_after_done", 32'(last_rd_cyc - done_cyc), 1);
        wait_count(1, d0 + 2, 200, "gate_done2");

        // asynchronous reset during data bit 3
        p0 = pops;
        d0 = dones;
        s0 = starts;
        a0 = aborts;
        push_word(vecs[3].data, vecs[3].frame);
        push_word(vecs[0].data, vecs[0].frame);
        wait_count(2, s0 + 1, 50, "rst_mid_start");
        repeat (CPB * 4 + 1) @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        check("rst_mid_tx", 32'(tx), 1);
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_rd_en", 32'(fifo_rd_en), 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        wait_count(1, d0 + 1, 200, "rst_mid_done");
        repeat (3) @(negedge clk);
        check("rst_mid_aborts", 32'(aborts - a0), 1);
        check("rst_mid_pops", 32'(pops - p0), 2);
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        check("rd_en_never_adjacent", 32'(adj_cnt), 0);

        // parameter sweep
        sw_go = 1'b1;
        n = 0;
        while (sw_fin < 6 && n < 40000) begin
            @(negedge clk);
            n++;
        end
        check("sweep_all_finished", 32'(sw_fin), 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Sweep: CLKS_PER_BIT in {2,5,16} x WIDTH in {8,9}
    for (genvar gi = 0; gi < 6; gi++) begin : g_sweep
        localparam int SW = (gi % 2 == 1) ? 9 : 8;
        localparam int SC = (gi / 2 == 0) ? 2 : ((gi / 2 == 1) ? 5 : 16);
        localparam int NW = 34;

        logic          s_empty = 1'b1;
        logic [SW-1:0] s_data = '0;
        logic          s_rd, s_tx, s_busy, s_done;
        logic          s_wr = 1'b0;
        logic [SW-1:0] s_wd = '0;
        logic [SW-1:0] s_q[$];
        logic [SW-1:0] s_exp[$];

        fifo_uart_tx #(.WIDTH(SW), .CLKS_PER_BIT(SC)) u_sw (
            .clk        (clk),
            .rstn       (rstn),
            .fifo_empty (s_empty),
            .fifo_data  (s_data),
            .fifo_rd_en (s_rd),
            .tx         (s_tx),
            .busy       (s_busy),
            .frame_done (s_done)
        );

        always @(posedge clk) begin
            if (s_rd && s_q.size() > 0) s_data <= s_q.pop_front();
            if (s_wr) s_q.push_back(s_wd);
            s_empty <= (s_q.size() == 0);
        end

        initial begin : drv
            int n;
            n = 0;
            wait (sw_go);
            while (n < NW) begin
                @(negedge clk);
                if (s_q.size() < 2 && $urandom_range(0, 3) == 0) begin
                    s_wd = SW'($urandom);
                    s_wr = 1'b1;
                    s_exp.push_back(s_wd);
                    n++;
                end else begin
                    s_wr = 1'b0;
                end
            end
            @(negedge clk);
            s_wr = 1'b0;
        end

        initial begin : rx
            logic [SW-1:0] d, e;
            logic st, sp;
            int got_n, budget;
            got_n = 0;
            budget = 0;
            wait (sw_go);
            while (got_n < NW && budget < 30000) begin
                @(negedge clk);
                budget++;
                if (s_tx === 1'b0) begin
                    repeat (SC / 2) @(negedge clk);
                    st = s_tx;
                    for (int k = 0; k < SW; k++) begin
                        repeat (SC) @(negedge clk);
                        d[k] = s_tx;
                    end
                    repeat (SC) @(negedge clk);
                    sp = s_tx;
                    budget += (SW + 1) * SC + SC / 2;
                    e = (s_exp.size() > 0) ? s_exp.pop_front() : ~d;
                    check($sformatf("sweep%0d_word", gi), 32'(d), 32'(e));
                    check($sformatf("sweep%0d_framing", gi), {30'd0, st, sp}, 32'd1);
                    $display("sweep w=%0d cpb=%0d word %0d: got 'h%0h expected 'h%0h", SW, SC, got_n, d, e);
                    got_n++;
                end
            end
            check($sformatf("sweep%0d_received", gi), 32'(got_n), NW);
            sweep_finished();
        end
    end

endmodule
